wb_write_arbiter: RTL and testbench

- Arbitrates between two writeback requesters (req0 = ALU pipe, req1 = memory pipe) that share the single register-file write port of the decode stage.
- The write port covers both the scalar and the vector register files: writeEnable, writeAddress, dataToSave, dataToSave_v, isvector_A, vect_esc_A and index_A.
- Each requester has a 2-entry FIFO with valid/ready handshake. The arbiter issues at most one registered write per cycle.

---
 rtl/wb_write_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: two requester FIFOs share one scalar/vector register-file write port.
// Define WBARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.

module wb_arb_fifo #(
    parameter int PW    = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [PW-1:0] din,
    output logic [PW-1:0] head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][PW-1:0] mem;
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            wr_ptr;

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

module wb_write_arbiter #(
    parameter int WIDTH        = 24,
    parameter int ADDRESSWIDTH = 4,
    parameter int VECTOR_WIDTH = 8,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 reqValid0,
    input  logic                                 reqValid1,
    output logic                                 reqReady0,
    output logic                                 reqReady1,
    input  logic [ADDRESSWIDTH-1:0]              reqAddress0,
    input  logic [ADDRESSWIDTH-1:0]              reqAddress1,
    input  logic [WIDTH-1:0]                     reqData0,
    input  logic [WIDTH-1:0]                     reqData1,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   reqData_v0,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   reqData_v1,
    input  logic                                 reqIsvector0,
    input  logic                                 reqIsvector1,
    input  logic                                 reqVectEsc0,
    input  logic                                 reqVectEsc1,
    input  logic [2:0]                           reqIndex0,
    input  logic [2:0]                           reqIndex1,
    output logic                                 writeEnable,
    output logic [ADDRESSWIDTH-1:0]              writeAddress,
    output logic [WIDTH-1:0]                     dataToSave,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   dataToSave_v,
    output logic                                 isvector_A,
    output logic                                 vect_esc_A,
    output logic [2:0]                           index_A,
    output logic                                 grant,
    output logic [$clog2(FIFO_DEPTH):0]          count0,
    output logic [$clog2(FIFO_DEPTH):0]          count1,
    output logic                                 idle
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDRESSWIDTH-1:0]            addr;
        logic [WIDTH-1:0]                   data;
        logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data_v;
        logic                               isvector;
        logic                               vect_esc;
        logic [2:0]                         index;
    } wb_req_t;

    wb_req_t [1:0]        req_in;
    wb_req_t [1:0]        head;
    wb_req_t              win;
    logic    [1:0]        valid;
    logic    [1:0]        ready;
    logic    [1:0]        push;
    logic    [1:0]        pop;
    logic    [1:0]        nonempty;
    logic    [1:0][CW-1:0] count;
    logic                 any;
    logic                 winner;

    always_comb begin
        req_in[0] = '{reqAddress0, reqData0, reqData_v0, reqIsvector0, reqVectEsc0, reqIndex0};
        req_in[1] = '{reqAddress1, reqData1, reqData_v1, reqIsvector1, reqVectEsc1, reqIndex1};
    end

    assign valid = {reqValid1, reqValid0};

    for (genvar g = 0; g < 2; g++) begin : g_req
        // Ready depends only on registered occupancy, so a same-cycle pop never re-opens it.
        assign ready[g]    = (count[g] != CW'(FIFO_DEPTH)) && reset;
        assign push[g]     = valid[g] && ready[g];
        assign pop[g]      = any && (winner == 1'(g));
        assign nonempty[g] = (count[g] != '0);

        wb_arb_fifo #(
            .PW    ($bits(wb_req_t)),
            .DEPTH (FIFO_DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (req_in[g]),
            .head  (head[g]),
            .count (count[g])
        );
    end

    assign any = |nonempty;

`ifdef WBARB_RR_EN
    logic rr_ptr;

    always_comb begin
        winner = nonempty[1];
        if (&nonempty)
            winner = rr_ptr;
    end

    // Pointer only moves on contention, handing the next tie to the loser.
    always_ff @(posedge clock) begin
        if (!reset)
            rr_ptr <= 1'b0;
        else if (&nonempty)
            rr_ptr <= ~winner;
    end
`else
    assign winner = ~nonempty[0];
`endif

    assign win = head[winner];

    always_ff @(posedge clock) begin
        if (!reset) begin
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            dataToSave   <= '0;
            dataToSave_v <= '0;
            isvector_A   <= 1'b0;
            vect_esc_A   <= 1'b0;
            index_A      <= '0;
            grant        <= 1'b0;
        end else begin
            writeEnable <= any;
            if (any) begin
                writeAddress <= win.addr;
                dataToSave   <= win.data;
                dataToSave_v <= win.data_v;
                isvector_A   <= win.isvector;
                vect_esc_A   <= win.vect_esc;
                index_A      <= win.index;
                grant        <= winner;
            end
        end
    end

    assign reqReady0 = ready[0];
    assign reqReady1 = ready[1];
    assign count0    = count[0];
    assign count1    = count[1];
    assign idle      = !reset || (!nonempty[0] && !nonempty[1] && !writeEnable);
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: vector table, burst ordering, full/pop and reset corner cases.
module tb_wb_write_arbiter;
    localparam int W  = 24;
    localparam int AW = 4;
    localparam int VW = 8;
    localparam int D  = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic reqValid0, reqValid1, reqReady0, reqReady1;
    logic [AW-1:0] reqAddress0, reqAddress1;
    logic [W-1:0]  reqData0, reqData1;
    logic [VW-1:0][W-1:0] reqData_v0, reqData_v1;
    logic reqIsvector0, reqIsvector1, reqVectEsc0, reqVectEsc1;
    logic [2:0] reqIndex0, reqIndex1;
    logic writeEnable;
    logic [AW-1:0] writeAddress;
    logic [W-1:0]  dataToSave;
    logic [VW-1:0][W-1:0] dataToSave_v;
    logic isvector_A, vect_esc_A, grant, idle;
    logic [2:0] index_A;
    logic [1:0] count0, count1;

    wb_write_arbiter dut (
        .clock(clock), .reset(reset),
        .reqValid0(reqValid0), .reqValid1(reqValid1),
        .reqReady0(reqReady0), .reqReady1(reqReady1),
        .reqAddress0(reqAddress0), .reqAddress1(reqAddress1),
        .reqData0(reqData0), .reqData1(reqData1),
        .reqData_v0(reqData_v0), .reqData_v1(reqData_v1),
        .reqIsvector0(reqIsvector0), .reqIsvector1(reqIsvector1),
        .reqVectEsc0(reqVectEsc0), .reqVectEsc1(reqVectEsc1),
        .reqIndex0(reqIndex0), .reqIndex1(reqIndex1),
        .writeEnable(writeEnable), .writeAddress(writeAddress),
        .dataToSave(dataToSave), .dataToSave_v(dataToSave_v),
        .isvector_A(isvector_A), .vect_esc_A(vect_esc_A), .index_A(index_A),
        .grant(grant), .count0(count0), .count1(count1), .idle(idle)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0]        addr;
        logic [W-1:0]         data;
        logic [VW-1:0][W-1:0] dv;
        logic                 isv;
        logic                 esc;
        logic [2:0]           idx;
    } pl_t;

    typedef struct {
        int         port;
        logic [3:0] addr;
        logic [23:0] data;
        logic [23:0] dv_base;
        logic       isv;
        logic       esc;
        logic [2:0] idx;
        logic [3:0] exp_addr;
        logic [23:0] exp_data;
        logic       exp_isv;
        logic       exp_esc;
        logic [2:0] exp_idx;
        logic       exp_grant;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    pl_t  sb0[$];
    pl_t  sb1[$];
    logic [3:0] wr_log[$];
    int   exp_c0, exp_c1;
    pl_t  mon_act, mon_exp;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_pl(input string name, input pl_t act, input pl_t exp);
        chk({name, "_addr"}, act.addr, exp.addr);
        chk({name, "_data"}, act.data, exp.data);
        chk({name, "_dv"},   act.dv,   exp.dv);
        chk({name, "_isv"},  act.isv,  exp.isv);
        chk({name, "_esc"},  act.esc,  exp.esc);
        chk({name, "_idx"},  act.idx,  exp.idx);
    endtask

    function automatic pl_t mkpl(input logic [3:0] a, input logic [23:0] d, input logic [23:0] base,
                                 input logic isv, input logic esc, input logic [2:0] idx);
        pl_t p;
        p.addr = a;
        p.data = d;
        for (int e = 0; e < VW; e++)
            p.dv[e] = base + 24'(e);
        p.isv = isv;
        p.esc = esc;
        p.idx = idx;
        return p;
    endfunction

    task automatic drive(input int port, input logic v, input pl_t p);
        if (port == 0) begin
            reqValid0 = v; reqAddress0 = p.addr; reqData0 = p.data; reqData_v0 = p.dv;
            reqIsvector0 = p.isv; reqVectEsc0 = p.esc; reqIndex0 = p.idx;
        end else begin
            reqValid1 = v; reqAddress1 = p.addr; reqData1 = p.data; reqData_v1 = p.dv;
            reqIsvector1 = p.isv; reqVectEsc1 = p.esc; reqIndex1 = p.idx;
        end
    endtask

    task automatic sb_push(input int port, input pl_t p);
        if (port == 0) sb0.push_back(p);
        else           sb1.push_back(p);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard side: FIFO occupancy is what was accepted minus what has already been issued.
    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_ready0", reqReady0, 1'b0);
            chk("rst_ready1", reqReady1, 1'b0);
            chk("rst_idle", idle, 1'b1);
        end else begin
            exp_c0 = sb0.size() - ((writeEnable === 1'b1 && grant === 1'b0) ? 1 : 0);
            exp_c1 = sb1.size() - ((writeEnable === 1'b1 && grant === 1'b1) ? 1 : 0);
            chk("count0", count0, exp_c0);
            chk("count1", count1, exp_c1);
            chk("ready0", reqReady0, exp_c0 != D);
            chk("ready1", reqReady1, exp_c1 != D);
            chk("idle", idle, exp_c0 == 0 && exp_c1 == 0 && writeEnable !== 1'b1);
            if (writeEnable === 1'b1) begin
                wr_log.push_back(writeAddress);
                mon_act.addr = writeAddress; mon_act.data = dataToSave; mon_act.dv = dataToSave_v;
                mon_act.isv = isvector_A; mon_act.esc = vect_esc_A; mon_act.idx = index_A;
                if (grant === 1'b0) begin
                    if (sb0.size() == 0) chk("stray_write0", writeEnable, 1'b0);
                    else begin mon_exp = sb0.pop_front(); cmp_pl("wr0", mon_act, mon_exp); end
                end else begin
                    if (sb1.size() == 0) chk("stray_write1", writeEnable, 1'b0);
                    else begin mon_exp = sb1.pop_front(); cmp_pl("wr1", mon_act, mon_exp); end
                end
            end
        end
    end

    vec_t tv[5];
    logic [3:0] exp_order[8];
    pl_t  p, p0, p1;
    int   i0, i1;
    logic a0, a1;

    initial begin
        tv[0] = '{0, 4'd5,  24'h00ABCD, 24'h000000, 1'b0, 1'b0, 3'd0, 4'd5,  24'h00ABCD, 1'b0, 1'b0, 3'd0, 1'b0};
        tv[1] = '{1, 4'd7,  24'h123456, 24'h000000, 1'b1, 1'b1, 3'd3, 4'd7,  24'h123456, 1'b1, 1'b1, 3'd3, 1'b1};
        tv[2] = '{1, 4'd15, 24'hFFFFFF, 24'hFFFFF8, 1'b0, 1'b0, 3'd7, 4'd15, 24'hFFFFFF, 1'b0, 1'b0, 3'd7, 1'b1};
        tv[3] = '{0, 4'd0,  24'h000000, 24'h000064, 1'b1, 1'b0, 3'd0, 4'd0,  24'h000000, 1'b1, 1'b0, 3'd0, 1'b0};
        tv[4] = '{0, 4'd10, 24'h800001, 24'hABC000, 1'b0, 1'b1, 3'd5, 4'd10, 24'h800001, 1'b0, 1'b1, 3'd5, 1'b0};
`ifdef WBARB_RR_EN
        exp_order = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4, 4'd12};
`else
        exp_order = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};
`endif

        // Reset held with both valids high.
        drive(0, 1'b1, mkpl(4'd3, 24'h111111, 24'h0, 1'b0, 1'b0, 3'd1));
        drive(1, 1'b1, mkpl(4'd4, 24'h222222, 24'h0, 1'b1, 1'b0, 3'd2));
        repeat (3) step();
        chk("rst_we", writeEnable, 1'b0);
        chk("rst_count0", count0, 2'd0);
        chk("rst_count1", count1, 2'd0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_addr", writeAddress, 4'd0);
        chk("rst_data", dataToSave, 24'd0);
        drive(0, 1'b0, p);
        drive(1, 1'b0, p);
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("post_rst_we", writeEnable, 1'b0);
        end

        // Single writes: latency, payload routing, grant and hold-when-idle.
        for (int i = 0; i < 5; i++) begin
            p = mkpl(tv[i].addr, tv[i].data, tv[i].dv_base, tv[i].isv, tv[i].esc, tv[i].idx);
            drive(tv[i].port, 1'b1, p);
            step();
            sb_push(tv[i].port, p);
            drive(tv[i].port, 1'b0, p);
            chk($sformatf("tv%0d_we_early", i), writeEnable, 1'b0);
            step();
            chk($sformatf("tv%0d_we", i), writeEnable, 1'b1);
            chk($sformatf("tv%0d_addr", i), writeAddress, tv[i].exp_addr);
            chk($sformatf("tv%0d_data", i), dataToSave, tv[i].exp_data);
            chk($sformatf("tv%0d_dv", i), dataToSave_v, mkpl(4'd0, 24'd0, tv[i].dv_base, 1'b0, 1'b0, 3'd0).dv);
            chk($sformatf("tv%0d_isv", i), isvector_A, tv[i].exp_isv);
            chk($sformatf("tv%0d_esc", i), vect_esc_A, tv[i].exp_esc);
            chk($sformatf("tv%0d_idx", i), index_A, tv[i].exp_idx);
            chk($sformatf("tv%0d_grant", i), grant, tv[i].exp_grant);
            step();
            chk($sformatf("tv%0d_we_off", i), writeEnable, 1'b0);
            chk($sformatf("tv%0d_idle", i), idle, 1'b1);
            chk($sformatf("tv%0d_hold_addr", i), writeAddress, tv[i].exp_addr);
            chk($sformatf("tv%0d_hold_grant", i), grant, tv[i].exp_grant);
        end

        // Back-to-back burst from both sides; blocked payloads change every cycle.
        wr_log.delete();
        i0 = 0;
        i1 = 0;
        for (int cyc = 0; cyc < 40 && (i0 < 4 || i1 < 4); cyc++) begin
            p0 = mkpl(4'(i0 + 1), {8'(cyc), 16'hA000 + 16'(i0)}, 24'(cyc * 16), 1'(i0), 1'b0, 3'(i0));
            p1 = mkpl(4'(i1 + 9), {8'(cyc), 16'hB000 + 16'(i1)}, 24'(cyc * 32), 1'b1, 1'(i1), 3'(i1 + 4));
            drive(0, i0 < 4, p0);
            drive(1, i1 < 4, p1);
            a0 = reqValid0 && reqReady0;
            a1 = reqValid1 && reqReady1;
            step();
            if (a0) begin sb0.push_back(p0); i0++; end
            if (a1) begin sb1.push_back(p1); i1++; end
        end
        drive(0, 1'b0, p0);
        drive(1, 1'b0, p1);
        chk("burst_accepted", i0 + i1, 8);
        for (int k = 0; k < 20 && !(idle && sb0.size() == 0 && sb1.size() == 0); k++) step();
        chk("burst_drained", idle, 1'b1);
        chk("order_len", wr_log.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < wr_log.size()) chk($sformatf("order%0d", k), wr_log[k], exp_order[k]);

        // Reset with entries queued in both FIFOs.
        for (int cyc = 0; cyc < 3; cyc++) begin
            p0 = mkpl(4'd2, 24'h0C0000 + 24'(cyc), 24'h5, 1'b0, 1'b0, 3'd1);
            p1 = mkpl(4'd6, 24'h0D0000 + 24'(cyc), 24'h9, 1'b1, 1'b1, 3'd6);
            drive(0, 1'b1, p0);
            drive(1, 1'b1, p1);
            a0 = reqReady0;
            a1 = reqReady1;
            step();
            if (a0) sb0.push_back(p0);
            if (a1) sb1.push_back(p1);
        end
        chk("pre_rst_occupied", count0 + count1 != 0, 1'b1);
        reset = 1'b0;
        sb0.delete();
        sb1.delete();
        repeat (2) step();
        chk("mid_rst_count0", count0, 2'd0);
        chk("mid_rst_count1", count1, 2'd0);
        chk("mid_rst_we", writeEnable, 1'b0);
        drive(0, 1'b0, p0);
        drive(1, 1'b0, p1);
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("no_stale_we", writeEnable, 1'b0);
        end

        // Full FIFO with a pop in the same cycle: ready reopens one cycle later.
        drive(0, 1'b1, mkpl(4'd1, 24'h0000A1, 24'h10, 1'b0, 1'b0, 3'd0));
        drive(1, 1'b1, mkpl(4'd8, 24'h0000B1, 24'h20, 1'b0, 1'b0, 3'd1));
        step();
        sb0.push_back(mkpl(4'd1, 24'h0000A1, 24'h10, 1'b0, 1'b0, 3'd0));
        sb1.push_back(mkpl(4'd8, 24'h0000B1, 24'h20, 1'b0, 1'b0, 3'd1));
        drive(0, 1'b0, p0);
        drive(1, 1'b1, mkpl(4'd9, 24'h0000B2, 24'h30, 1'b1, 1'b0, 3'd2));
        chk("fp_ready1_open", reqReady1, 1'b1);
        step();
        sb1.push_back(mkpl(4'd9, 24'h0000B2, 24'h30, 1'b1, 1'b0, 3'd2));
        chk("fp_count1_full", count1, 2'd2);
        chk("fp_ready1_full", reqReady1, 1'b0);
        drive(1, 1'b1, mkpl(4'd13, 24'hDEAD00, 24'h40, 1'b1, 1'b1, 3'd7));
        step();
        chk("fp_count1_pop", count1, 2'd1);
        chk("fp_ready1_reopen", reqReady1, 1'b1);
        drive(1, 1'b1, mkpl(4'd11, 24'h0000B3, 24'h50, 1'b0, 1'b1, 3'd3));
        step();
        sb1.push_back(mkpl(4'd11, 24'h0000B3, 24'h50, 1'b0, 1'b1, 3'd3));
        chk("fp_count1_pushpop", count1, 2'd1);
        drive(1, 1'b0, p1);
        for (int k = 0; k < 10 && !(idle && sb0.size() == 0 && sb1.size() == 0); k++) step();
        chk("fp_drained", idle, 1'b1);
        chk("fp_sb_empty", sb0.size() + sb1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
